// File: rtl/tone_pkg.sv
// Shared types and constants for the tone generator, note display and keyboard scanner.
package tone_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDiv,
    StRun
  } tone_state_e;

  localparam int unsigned CLK_HZ_DEFAULT = 100_000_000;

  // Note frequencies in Hz, octave 4.
  localparam logic [11:0] NOTE_C = 12'd261;
  localparam logic [11:0] NOTE_D = 12'd294;
  localparam logic [11:0] NOTE_E = 12'd330;
  localparam logic [11:0] NOTE_F = 12'd349;
  localparam logic [11:0] NOTE_G = 12'd392;
  localparam logic [11:0] NOTE_A = 12'd440;
  localparam logic [11:0] NOTE_B = 12'd494;

endpackage

// File: rtl/tone_gen_if.sv
// Frequency request and speaker-side status bundle of the tone generator.
interface tone_gen_if #(
  parameter int unsigned FREQ_W = 12,
  parameter int unsigned CNT_W  = 26
);
  logic [FREQ_W-1:0] freq;
  logic              en;
  logic              tone_out;
  logic              busy;
  logic [CNT_W-1:0]  half_period;

  modport master (output freq, output en, input tone_out, input busy, input half_period);
  modport slave  (input freq, input en, output tone_out, output busy, output half_period);
endinterface

// File: rtl/tone_div.sv
// Iterative restoring divider: CLK_HZ / divisor, one quotient bit per cycle, MSB first.
module tone_div
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT,
  parameter int unsigned FREQ_W = 12,
  parameter int unsigned CNT_W  = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [FREQ_W:0]   divisor_i,
  output logic              done_o,
  output logic [CNT_W-1:0]  quotient_o
);

  localparam int unsigned RemW    = FREQ_W + 2;
  localparam int unsigned IdxW    = $clog2(CNT_W + 1);
  // One extra dividend bit: CLK_HZ may exceed 2^CNT_W; that bit preloads the remainder.
  localparam logic [CNT_W:0] Dividend = (CNT_W + 1)'(CLK_HZ);

  logic [RemW-1:0]  rem_q, rem_d;
  logic [FREQ_W:0]  dvs_q, dvs_d;
  logic [CNT_W-1:0] quo_q, quo_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             act_q, act_d;

  logic [RemW-1:0]  trial;
  logic [RemW:0]    diff;
  logic             qbit;

  always_comb begin
    trial      = (rem_q << 1) | RemW'(Dividend[idx_q]);
    diff       = {1'b0, trial} - (RemW + 1)'(dvs_q);
    qbit       = ~diff[RemW];
    quotient_o = (quo_q << 1) | CNT_W'(qbit);
    done_o     = 1'b0;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    quo_d      = quo_q;
    idx_d      = idx_q;
    act_d      = act_q;
    if (start_i) begin
      // Restart discards any division in flight.
      dvs_d = divisor_i;
      rem_d = RemW'(Dividend[CNT_W]);
      quo_d = '0;
      idx_d = IdxW'(CNT_W - 1);
      act_d = 1'b1;
    end else if (act_q) begin
      rem_d = qbit ? diff[RemW-1:0] : trial;
      quo_d = quotient_o;
      if (idx_q == '0) begin
        act_d  = 1'b0;
        done_o = 1'b1;
      end else begin
        idx_d = idx_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      idx_q <= '0;
      act_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      quo_q <= quo_d;
      idx_q <= idx_d;
      act_q <= act_d;
    end
  end

endmodule

// File: rtl/tone_gen.sv
// Square-wave tone generator: frequency-change detector, divide/run FSM and half-period counter.
module tone_gen
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT,
  parameter int unsigned FREQ_W = 12,
  parameter int unsigned CNT_W  = 26
) (
  input logic        clk,
  input logic        rst,
  tone_gen_if.slave  bus
);

  tone_state_e       state_q, state_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  hp_q, hp_d;
  logic              tone_q, tone_d;
  logic              busy_q, busy_d;

  logic              div_start;
  logic              div_done;
  logic [CNT_W-1:0]  div_quo;

  tone_div #(
    .CLK_HZ (CLK_HZ),
    .FREQ_W (FREQ_W),
    .CNT_W  (CNT_W)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .divisor_i  ({bus.freq, 1'b0}),
    .done_o     (div_done),
    .quotient_o (div_quo)
  );

  always_comb begin
    state_d   = state_q;
    freq_d    = freq_q;
    cnt_d     = cnt_q;
    hp_d      = hp_q;
    tone_d    = tone_q;
    busy_d    = busy_q;
    div_start = 1'b0;
    if (bus.freq != freq_q) begin
      // A new frequency overrides everything, including an en change in the same cycle.
      freq_d = bus.freq;
      tone_d = 1'b0;
      cnt_d  = '0;
      if (bus.freq == '0) begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end else begin
        state_d   = StDiv;
        busy_d    = 1'b1;
        div_start = 1'b1;
      end
    end else begin
      case (state_q)
        StIdle: begin
          tone_d = 1'b0;
        end
        StDiv: begin
          if (div_done) begin
            hp_d    = (div_quo == '0) ? CNT_W'(1) : div_quo;
            busy_d  = 1'b0;
            cnt_d   = '0;
            state_d = StRun;
          end
        end
        StRun: begin
          if (!bus.en) begin
            tone_d = 1'b0;
            cnt_d  = '0;
          end else if (cnt_q == hp_q - CNT_W'(1)) begin
            tone_d = ~tone_q;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = StIdle;
          tone_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      freq_q  <= '0;
      cnt_q   <= '0;
      hp_q    <= '0;
      tone_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      freq_q  <= freq_d;
      cnt_q   <= cnt_d;
      hp_q    <= hp_d;
      tone_q  <= tone_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.tone_out    = tone_q;
  assign bus.busy        = busy_q;
  assign bus.half_period = hp_q;

endmodule

// File: tb/tb_tone_gen.sv
// Directed bench for tone_gen at CLK_HZ=1 MHz, CNT_W=20.
module tb_tone_gen;
  import tone_pkg::*;

  localparam int unsigned ClkHz = 1_000_000;
  localparam int unsigned FreqW = 12;
  localparam int unsigned CntW  = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  tone_gen_if #(.FREQ_W(FreqW), .CNT_W(CntW)) bus ();

  tone_gen #(
    .CLK_HZ (ClkHz),
    .FREQ_W (FreqW),
    .CNT_W  (CntW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until tone_out equals lvl; n saturates at 20000 if it never does.
  task automatic wait_level(input logic lvl, output int n);
    n = 0;
    while (bus.tone_out !== lvl && n < 20000) begin
      tick();
      n++;
    end
  endtask

  // Counts cycles busy stays high from the current sample point.
  task automatic count_busy(output int n, output int tone_hi);
    n = 0;
    tone_hi = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      if (bus.tone_out !== 1'b0) tone_hi++;
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    bus.freq = '0;
    bus.en   = 1'b0;
    tick();
    n_vec++;
    if (bus.tone_out !== 1'b0) begin n_err++; $display("FAIL reset_tone got %b want 0", bus.tone_out); end
    n_vec++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_vec++;
    if (bus.half_period !== '0) begin
      n_err++; $display("FAIL reset_hp got %0d want 0", bus.half_period);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic check_tone(input string name, input logic [FreqW-1:0] f, input int hp);
    int n, hi;
    bus.freq = f;
    tick();
    count_busy(n, hi);
    n_vec++;
    if (n != 20) begin n_err++; $display("FAIL %s_busy_len got %0d want 20", name, n); end
    n_vec++;
    if (hi != 0) begin n_err++; $display("FAIL %s_tone_in_div got %0d high want 0", name, hi); end
    n_vec++;
    if (bus.half_period !== CntW'(hp)) begin
      n_err++; $display("FAIL %s_hp got %0d want %0d", name, bus.half_period, hp);
    end
    wait_level(1'b1, n);
    n_vec++;
    if (n != hp) begin n_err++; $display("FAIL %s_first_rise got %0d want %0d", name, n, hp); end
    wait_level(1'b0, n);
    n_vec++;
    if (n != hp) begin n_err++; $display("FAIL %s_high_len got %0d want %0d", name, n, hp); end
    wait_level(1'b1, n);
    n_vec++;
    if (n != hp) begin n_err++; $display("FAIL %s_low_len got %0d want %0d", name, n, hp); end
  endtask

  task automatic test_tone_440();
    bus.en = 1'b1;
    check_tone("a440", NOTE_A, 1136);
  endtask

  task automatic test_back_to_back();
    check_tone("c261", NOTE_C, 1915);
    // Currently high: a new freq must pull the output low at the detection edge.
    check_tone("b494", NOTE_B, 1012);
  endtask

  task automatic test_silence();
    int toggles;
    logic prev;
    bus.freq = '0;
    tick();
    n_vec++;
    if (bus.tone_out !== 1'b0) begin n_err++; $display("FAIL sil_tone got %b want 0", bus.tone_out); end
    n_vec++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL sil_busy got %b want 0", bus.busy); end
    toggles = 0;
    prev = bus.tone_out;
    for (int i = 0; i < 10000; i++) begin
      tick();
      if (bus.tone_out !== prev || bus.busy !== 1'b0) toggles++;
      prev = bus.tone_out;
    end
    n_vec++;
    if (toggles != 0) begin n_err++; $display("FAIL sil_activity got %0d want 0", toggles); end
  endtask

  task automatic test_abort();
    int n, hi, bad;
    bad = 0;
    bus.freq = NOTE_A;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (bus.half_period === CntW'(1136)) bad++;
      tick();
    end
    bus.freq = NOTE_E;
    tick();
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      if (bus.half_period === CntW'(1136)) bad++;
      tick();
      n++;
    end
    n_vec++;
    if (n != 20) begin n_err++; $display("FAIL abort_busy_len got %0d want 20", n); end
    n_vec++;
    if (bus.half_period !== CntW'(1515)) begin
      n_err++; $display("FAIL abort_hp got %0d want 1515", bus.half_period);
    end
    for (int i = 0; i < 3000; i++) begin
      if (bus.half_period === CntW'(1136)) bad++;
      tick();
    end
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL abort_stale_hp got %0d want 0", bad); end
    hi = 0;
  endtask

  task automatic test_en_gate();
    int n, hi;
    wait_level(1'b1, n);
    bus.en = 1'b0;
    tick();
    n_vec++;
    if (bus.tone_out !== 1'b0) begin n_err++; $display("FAIL en_off_tone got %b want 0", bus.tone_out); end
    hi = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (bus.tone_out !== 1'b0) hi++;
    end
    n_vec++;
    if (hi != 0) begin n_err++; $display("FAIL en_off_hold got %0d high want 0", hi); end
    bus.en = 1'b1;
    wait_level(1'b1, n);
    n_vec++;
    if (n != 1515) begin n_err++; $display("FAIL en_resume_rise got %0d want 1515", n); end
  endtask

  task automatic test_async_reset();
    int n, hi;
    bus.freq = NOTE_G;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.busy !== 1'b0 || bus.tone_out !== 1'b0 || bus.half_period !== '0) begin
      n_err++;
      $display("FAIL rst_mid_div got busy=%b tone=%b hp=%0d want 0/0/0",
               bus.busy, bus.tone_out, bus.half_period);
    end
    tick();
    rst = 1'b0;
    tick();
    count_busy(n, hi);
    n_vec++;
    if (n != 20) begin n_err++; $display("FAIL rst_restart_busy got %0d want 20", n); end
    n_vec++;
    if (bus.half_period !== CntW'(1275)) begin
      n_err++; $display("FAIL rst_restart_hp got %0d want 1275", bus.half_period);
    end
    wait_level(1'b1, n);
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.busy !== 1'b0 || bus.tone_out !== 1'b0 || bus.half_period !== '0) begin
      n_err++;
      $display("FAIL rst_mid_run got busy=%b tone=%b hp=%0d want 0/0/0",
               bus.busy, bus.tone_out, bus.half_period);
    end
    tick();
    rst = 1'b0;
    tick();
    n_vec++;
    if (bus.busy !== 1'b1) begin n_err++; $display("FAIL rst_run_restart got %b want 1", bus.busy); end
  endtask

  initial begin
    bus.freq = '0;
    bus.en   = 1'b0;
    test_reset();
    test_tone_440();
    test_back_to_back();
    test_silence();
    test_abort();
    test_en_gate();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
